rsa_seq_ctrl: RTL and testbench
===============================

RSA_SEQ_CTRL -- requirements
Module: rsa_seq_ctrl

Interface
REQ-001 The block SHALL have parameter SLICE_W, default 4, giving the width of the shared adder slice.
REQ-002 The block SHALL have parameter NUM_SLICES, default 4, giving the number of slices per operand; operand width W = SLICE_W*NUM_SLICES.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: a request is present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept a request.
REQ-007 The block SHALL have port op, input, 1 bit: 0 = add A+B, 1 = subtract A-B.
REQ-008 The block SHALL have ports a and b, inputs, W bits each: operands, two's complement.
REQ-009 The block SHALL have port abort, input, 1 bit: synchronous discard of the current operation.
REQ-010 The block SHALL have port out_valid, output, 1 bit: the result is available.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-012 The block SHALL have port sum, output, W bits: the result.
REQ-013 The block SHALL have port cout, output, 1 bit: final carry; for subtraction 1 = no borrow.
REQ-014 The block SHALL have port ovf, output, 1 bit: signed overflow.
REQ-015 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE.
REQ-018 On accept (in_valid & in_ready), the block SHALL latch a, latch b (bitwise inverted when op=1), set carry = op, set slice index = 0 and go to RUN.
REQ-019 Each RUN cycle SHALL add slice[idx] of the latched A and B' with the carry, write the SLICE_W result bits into sum slice idx, update carry with the slice carry-out and increment idx.
REQ-020 When idx = NUM_SLICES-1, RUN SHALL go to DONE at the same edge that writes the last slice.
REQ-021 out_valid SHALL be high exactly NUM_SLICES cycles after the accept edge.
REQ-022 Latency SHALL be independent of operand values.
REQ-023 ovf SHALL equal (A[W-1] == B'[W-1]) & (sum[W-1] != A[W-1]).
REQ-024 In DONE, out_valid SHALL be 1 and sum, cout and ovf SHALL be held stable until out_valid & out_ready.
REQ-025 The out_valid & out_ready handshake in DONE SHALL return the FSM to IDLE; in_ready SHALL rise on the following cycle, so there is no same-cycle re-accept.
REQ-026 If out_ready is already high when DONE is entered, the handshake SHALL complete in that first DONE cycle.
REQ-027 in_valid held high in RUN or DONE SHALL be ignored and SHALL NOT corrupt the latched operands.
REQ-028 abort SHALL move any state to IDLE on the next edge, clear out_valid and discard the result.
REQ-029 abort SHALL take priority over accept and over the output handshake in the same cycle.
REQ-030 sum SHALL be 0 whenever out_valid = 0.

Reset
REQ-031 rst_n low SHALL immediately force IDLE, idx=0, carry=0, sum=0, cout=0, ovf=0, out_valid=0 and busy=0; in_ready=1 while in IDLE.
REQ-032 Reset mid-RUN SHALL discard the partial result, and no out_valid SHALL appear after release.
REQ-033 Reset release SHALL be accepted on any clock phase, and the first accept is allowed on the first edge after release.

Structure
REQ-034 Package rsa_ctrl_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the op encoding constants OP_ADD=0 and OP_SUB=1.
REQ-035 One sub-module, slice_adder (SLICE_W-bit ripple adder with plain carry-in and no operand inversion), SHALL be instantiated once and time-shared across slices.
REQ-036 Operand inversion SHALL be done in the controller, not in the sub-module.
REQ-037 Slice selection SHALL be by an idx-driven mux, with no W-bit adder anywhere in the block.

Verification (defaults SLICE_W=4, NUM_SLICES=4)
REQ-038 add 0x1234 + 0x0FFF -> sum 0x2233, cout 0, ovf 0, out_valid exactly 4 cycles after accept.
REQ-039 add 0xFFFF + 0x0001 -> sum 0x0000, cout 1, ovf 0; add 0x7FFF + 0x0001 -> sum 0x8000, ovf 1.
REQ-040 sub 0x8000 - 0x0001 -> sum 0x7FFF, cout 1, ovf 1; sub 0x0000 - 0x0001 -> sum 0xFFFF, cout 0, ovf 0.
REQ-041 out_ready low for 5 cycles in DONE -> sum, cout and ovf stable; in_ready 0; in_valid with new operands is ignored; after out_ready rises, IDLE is reached and in_ready = 1 the next cycle.
REQ-042 abort asserted with idx=2 -> IDLE next cycle and no out_valid; then a new add 0x0001 + 0x0001 -> sum 0x0002 after 4 cycles.
REQ-043 rst_n pulsed low mid-RUN, asynchronously between edges -> outputs cleared immediately and no out_valid after release.

Source files
------------

// File: rtl/rsa_ctrl_pkg.sv
// Shared types for the slice-sequenced add/subtract controller.
//   state_e        : controller FSM states
//   OP_ADD/OP_SUB  : encoding of the op request bit
//   idx_width()    : width of a slice index counter (never below 1 bit)
package rsa_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rsa_seq_ctrl_if.sv
// Request/response bundle of rsa_seq_ctrl.
//   in_valid/in_ready   : request handshake, with op, a, b
//   abort               : synchronous discard of the current operation
//   out_valid/out_ready : result handshake, with sum, cout, ovf
//   busy                : controller is not idle
interface rsa_seq_ctrl_if #(
  parameter int unsigned SLICE_W    = 4,
  parameter int unsigned NUM_SLICES = 4
);
  localparam int unsigned W = SLICE_W * NUM_SLICES;

  logic         in_valid;
  logic         in_ready;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         abort;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  modport master (
    output in_valid, op, a, b, abort, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, op, a, b, abort, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/rsa_seq_ctrl_slice_adder.sv
// slice_adder: SLICE_W-bit ripple-carry adder, plain carry-in, no inversion.
//   i_a, i_b : slice operands
//   i_ci     : carry in
//   o_s_c    : slice sum (combinational)
//   o_co_c   : carry out (combinational)
module slice_adder #(
  parameter int unsigned SLICE_W = 4
) (
  input  logic [SLICE_W-1:0] i_a,
  input  logic [SLICE_W-1:0] i_b,
  input  logic               i_ci,
  output logic [SLICE_W-1:0] o_s_c,
  output logic               o_co_c
);

  // Explicit full-adder chain, LSB first.
  always_comb begin
    logic w_c;
    o_s_c = '0;
    w_c   = i_ci;
    for (int i = 0; i < int'(SLICE_W); i++) begin
      o_s_c[i] = i_a[i] ^ i_b[i] ^ w_c;
      w_c      = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
    end
    o_co_c = w_c;
  end

endmodule

// File: rtl/rsa_seq_ctrl.sv
// rsa_seq_ctrl: W-bit add/subtract computed one SLICE_W slice per cycle
// through a single shared slice_adder.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : rsa_seq_ctrl_if slave (request, abort, result, busy)
module rsa_seq_ctrl
  import rsa_ctrl_pkg::*;
#(
  parameter int unsigned SLICE_W    = 4,
  parameter int unsigned NUM_SLICES = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  rsa_seq_ctrl_if.slave bus
);

  localparam int unsigned W     = SLICE_W * NUM_SLICES;
  localparam int unsigned IDX_W = idx_width(NUM_SLICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [W-1:0]       r_acc;
  logic [W-1:0]       r_sum;
  logic [IDX_W-1:0]   r_idx;
  logic               r_carry;
  logic               r_cout;
  logic               r_ovf;

  logic [SLICE_W-1:0] w_slice_a;
  logic [SLICE_W-1:0] w_slice_b;
  logic [SLICE_W-1:0] w_slice_s;
  logic               w_slice_co;
  logic [W-1:0]       w_acc_nxt;
  logic               w_last;

  // Slice selection mux; only this slice goes through the adder.
  assign w_slice_a = r_a[r_idx*SLICE_W +: SLICE_W];
  assign w_slice_b = r_b[r_idx*SLICE_W +: SLICE_W];
  assign w_last    = (r_idx == LAST_IDX);

  slice_adder #(.SLICE_W(SLICE_W)) u_slice_adder (
    .i_a    (w_slice_a),
    .i_b    (w_slice_b),
    .i_ci   (r_carry),
    .o_s_c  (w_slice_s),
    .o_co_c (w_slice_co)
  );

  // Accumulator with the current slice merged in.
  always_comb begin
    w_acc_nxt = r_acc;
    w_acc_nxt[r_idx*SLICE_W +: SLICE_W] = w_slice_s;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state; abort overrides both accept and the result handshake.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.abort) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (bus.in_valid)  w_state_nxt = RUN;
        RUN:     if (w_last)        w_state_nxt = DONE;
        DONE:    if (bus.out_ready) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Datapath: operand latch, slice stepping, result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (bus.abort) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a     <= bus.a;
            r_b     <= (bus.op == OP_SUB) ? ~bus.b : bus.b;
            r_carry <= bus.op;
            r_idx   <= '0;
            r_acc   <= '0;
          end
        end
        RUN: begin
          r_acc   <= w_acc_nxt;
          r_carry <= w_slice_co;
          r_idx   <= r_idx + 1'b1;
          // Last slice: publish the full result in the same edge.
          if (w_last) begin
            r_idx  <= '0;
            r_sum  <= w_acc_nxt;
            r_cout <= w_slice_co;
            r_ovf  <= (r_a[W-1] == r_b[W-1]) & (w_slice_s[SLICE_W-1] != r_a[W-1]);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_rsa_seq_ctrl.sv
// Directed bench for rsa_seq_ctrl (SLICE_W=4, NUM_SLICES=4).
module tb_rsa_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  rsa_seq_ctrl_if #(.SLICE_W(4), .NUM_SLICES(4)) bus ();

  rsa_seq_ctrl #(.SLICE_W(4), .NUM_SLICES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one request with out_ready high; check 4-cycle latency, result
  // and return to idle. Leaves the bench just after a falling edge.
  task automatic run_op(input logic o, input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] es, input logic ec, input logic eo,
                        input string tag);
    bus.in_valid  = 1'b1;
    bus.op        = o;
    bus.a         = av;
    bus.b         = bv;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_wait_valid"}, 32'(bus.out_valid), 32'd0);
      if (k == 0) begin
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        chk({tag, "_sum_zero_run"}, 32'(bus.sum), 32'd0);
      end
      @(negedge clk);
    end
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_sum"},   32'(bus.sum),       32'(es));
    chk({tag, "_cout"},  32'(bus.cout),      32'(ec));
    chk({tag, "_ovf"},   32'(bus.ovf),       32'(eo));
    @(negedge clk);
    chk({tag, "_in_ready_after"}, 32'(bus.in_ready),  32'd1);
    chk({tag, "_valid_after"},    32'(bus.out_valid), 32'd0);
    chk({tag, "_sum_after"},      32'(bus.sum),       32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    #3;
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_sum",       32'(bus.sum),       32'd0);
    chk("rst_cout",      32'(bus.cout),      32'd0);
    chk("rst_ovf",       32'(bus.ovf),       32'd0);
    #20 rst_n = 1'b1;
    @(negedge clk);

    // Arithmetic vectors
    run_op(1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, "add_1234_0fff");
    run_op(1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, "add_ffff_0001");
    run_op(1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1, "add_7fff_0001");
    run_op(1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1, "sub_8000_0001");
    run_op(1'b1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, "sub_0000_0001");

    // Stall in DONE for 5 cycles with a competing request present
    bus.in_valid  = 1'b1;
    bus.op        = 1'b0;
    bus.a         = 16'h1234;
    bus.b         = 16'h0FFF;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid",    32'(bus.out_valid), 32'd1);
      chk("stall_sum",      32'(bus.sum),       32'h2233);
      chk("stall_cout",     32'(bus.cout),      32'd0);
      chk("stall_ovf",      32'(bus.ovf),       32'd0);
      chk("stall_in_ready", 32'(bus.in_ready),  32'd0);
      bus.in_valid = 1'b1;
      bus.op       = 1'b1;
      bus.a        = 16'hAAAA;
      bus.b        = 16'h5555;
      @(negedge clk);
    end
    chk("stall_sum_end", 32'(bus.sum), 32'h2233);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_in_ready", 32'(bus.in_ready),  32'd1);
    chk("stall_release_valid",    32'(bus.out_valid), 32'd0);
    chk("stall_release_busy",     32'(bus.busy),      32'd0);

    // Abort beats accept in IDLE
    bus.in_valid = 1'b1;
    bus.abort    = 1'b1;
    bus.a        = 16'h0005;
    bus.b        = 16'h0005;
    @(negedge clk);
    chk("abort_idle_busy",     32'(bus.busy),     32'd0);
    chk("abort_idle_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b0;
    bus.abort    = 1'b0;
    @(negedge clk);

    // Abort while idx = 2
    bus.in_valid = 1'b1;
    bus.op       = 1'b0;
    bus.a        = 16'hFFFF;
    bus.b        = 16'hFFFF;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    chk("abort_run_busy",     32'(bus.busy),      32'd0);
    chk("abort_run_in_ready", 32'(bus.in_ready),  32'd1);
    chk("abort_run_valid",    32'(bus.out_valid), 32'd0);
    bus.abort = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("abort_no_valid", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
    end
    run_op(1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, "add_after_abort");

    // Asynchronous reset mid-RUN
    bus.in_valid = 1'b1;
    bus.a        = 16'h1111;
    bus.b        = 16'h2222;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy",     32'(bus.busy),      32'd0);
    chk("arst_in_ready", 32'(bus.in_ready),  32'd1);
    chk("arst_valid",    32'(bus.out_valid), 32'd0);
    chk("arst_sum",      32'(bus.sum),       32'd0);
    #6 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("arst_no_valid", 32'(bus.out_valid), 32'd0);
      chk("arst_idle",     32'(bus.busy),      32'd0);
    end

    // Accept on the very first edge after a reset release
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    run_op(1'b1, 16'h0010, 16'h0003, 16'h000D, 1'b1, 1'b0, "sub_first_edge");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
